// File: rtl/swg_pkg.sv
// Shared types, widths and window-offset helper for the sliding window generator.
// The SWG_COORD_EN build option is handled in sliding_window_gen itself.
package swg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } swg_state_e;

   localparam int SWG_DATA_W = 8;
   localparam int SWG_WIN    = 3;
   localparam int WIN_BITS   = SWG_WIN * SWG_WIN * SWG_DATA_W;

   // Bit offset of window element (r,c); r=0 is the oldest row, c=0 the leftmost column.
   function automatic int win_idx(input int r, input int c, input int win, input int data_w);
      return (r * win + c) * data_w;
   endfunction

endpackage

// File: rtl/swg_line_buf.sv
// One image line of pixel storage: combinational read, synchronous write.
// The storage is deliberately not reset.
module swg_line_buf
   import swg_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 540,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign rd_data = mem[addr];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wr_data;
   end

endmodule

// File: rtl/sliding_window_gen.sv
// Raster stream to WIN x WIN window generator with line buffers and a single output register.
// Define SWG_COORD_EN to add win_row_o/win_col_o (bottom-right pixel coordinates of each window).
module sliding_window_gen
   import swg_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int MAX_COLS = 540,
   parameter int WIN      = 3,
   parameter int COL_W    = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   input  logic [COL_W-1:0]          cfg_cols_i,
   input  logic [COL_W-1:0]          cfg_rows_i,
   output logic                      busy_o,
   output logic                      done_o,
   input  logic [DATA_W-1:0]         pix_i,
   input  logic                      pix_valid_i,
   output logic                      pix_ready_o,
   output logic [WIN*WIN*DATA_W-1:0] win_o,
   output logic                      win_valid_o,
   input  logic                      win_ready_i,
`ifdef SWG_COORD_EN
   output logic [COL_W-1:0]          win_row_o,
   output logic [COL_W-1:0]          win_col_o,
`endif
   output logic [1:0]                dbg_state_o
);

   localparam int WIN_O_W = WIN * WIN * DATA_W;

   // Handshakes: a transfer happens on a clock edge where valid and ready are both high;
   // a raised valid holds its data stable until that transfer.
   swg_state_e         state_q, state_d;
   logic [COL_W-1:0]   cols_q, rows_q, row_q, col_q;
   logic [DATA_W-1:0]  win_sr_q [WIN][WIN];
   logic [DATA_W-1:0]  win_nx   [WIN][WIN];
   logic [DATA_W-1:0]  lb_rd    [WIN-1];
   logic [WIN_O_W-1:0] win_flat, win_q;
   logic               win_valid_q, done_q;
   logic               cfg_ok, start_ok, pix_ready, accept, produce;
   logic               last_col, last_pix, drain_exit;

   assign cfg_ok     = (cfg_cols_i >= COL_W'(WIN)) && (cfg_cols_i <= COL_W'(MAX_COLS)) &&
                       (cfg_rows_i >= COL_W'(WIN));
   assign start_ok   = (state_q == ST_IDLE) && start_i && cfg_ok;
   assign pix_ready  = (state_q == ST_RUN) && (!win_valid_q || win_ready_i);
   assign accept     = pix_valid_i && pix_ready;
   assign last_col   = (col_q == cols_q - COL_W'(1));
   assign last_pix   = last_col && (row_q == rows_q - COL_W'(1));
   // First WIN-1 columns of each row only prime the window, so rows never straddle.
   assign produce    = accept && (row_q >= COL_W'(WIN - 1)) && (col_q >= COL_W'(WIN - 1));
   assign drain_exit = (state_q == ST_DRAIN) && (!win_valid_q || win_ready_i);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_ok) state_d = ST_RUN;
         ST_RUN:   if (accept && last_pix) state_d = ST_DRAIN;
         ST_DRAIN: if (drain_exit) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Shift left one column; the new right column is {oldest line ... newest line, pix_i}.
   always_comb begin
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN - 1; c++) win_nx[r][c] = win_sr_q[r][c+1];
         win_nx[r][WIN-1] = pix_i;
      end
      for (int r = 0; r < WIN - 1; r++) win_nx[r][WIN-1] = lb_rd[WIN-2-r];
   end

   always_comb begin
      win_flat = '0;
      for (int r = 0; r < WIN; r++)
         for (int c = 0; c < WIN; c++)
            win_flat[win_idx(r, c, WIN, DATA_W) +: DATA_W] = win_nx[r][c];
   end

   for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
      logic [DATA_W-1:0] wr_data;
      if (k == 0) begin : g_head
         assign wr_data = pix_i;
      end else begin : g_tail
         assign wr_data = lb_rd[k-1];
      end
      swg_line_buf #(.DATA_W(DATA_W), .DEPTH(MAX_COLS), .ADDR_W(COL_W)) u_lb (
         .clk     (clk),
         .we      (accept),
         .addr    (col_q),
         .wr_data (wr_data),
         .rd_data (lb_rd[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cols_q      <= '0;
         rows_q      <= '0;
         row_q       <= '0;
         col_q       <= '0;
         win_q       <= '0;
         win_valid_q <= 1'b0;
         done_q      <= 1'b0;
         for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++) win_sr_q[r][c] <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= drain_exit;
         if (start_ok) begin
            cols_q <= cfg_cols_i;
            rows_q <= cfg_rows_i;
            row_q  <= '0;
            col_q  <= '0;
         end else if (accept) begin
            if (last_col) begin
               col_q <= '0;
               row_q <= last_pix ? '0 : row_q + COL_W'(1);
            end else begin
               col_q <= col_q + COL_W'(1);
            end
         end
         if (accept) win_sr_q <= win_nx;
         if (produce) begin
            win_q       <= win_flat;
            win_valid_q <= 1'b1;
         end else if (win_ready_i) begin
            win_valid_q <= 1'b0;
         end
      end
   end

`ifdef SWG_COORD_EN
   logic [COL_W-1:0] win_row_q, win_col_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_row_q <= '0;
         win_col_q <= '0;
      end else if (produce) begin
         win_row_q <= row_q;
         win_col_q <= col_q;
      end
   end

   assign win_row_o = win_row_q;
   assign win_col_o = win_col_q;
`endif

   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done_q;
   assign pix_ready_o = pix_ready;
   assign win_o       = win_q;
   assign win_valid_o = win_valid_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sliding_window_gen.sv
// Scoreboard bench for sliding_window_gen: directed frames, stalls, bad configs and mid-frame reset.
// Build with SWG_COORD_EN defined to also check window coordinates.
module tb_sliding_window_gen;
   import swg_pkg::*;

   localparam int DATA_W   = 8;
   localparam int MAX_COLS = 540;
   localparam int WIN      = 3;
   localparam int COL_W    = 10;
   localparam int WB       = WIN * WIN * DATA_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start_i = 1'b0;
   logic [COL_W-1:0]  cfg_cols_i = '0;
   logic [COL_W-1:0]  cfg_rows_i = '0;
   logic              busy_o, done_o;
   logic [DATA_W-1:0] pix_i = '0;
   logic              pix_valid_i = 1'b0;
   logic              pix_ready_o;
   logic [WB-1:0]     win_o;
   logic              win_valid_o;
   logic              win_ready_i = 1'b1;
   logic [1:0]        dbg_state_o;
`ifdef SWG_COORD_EN
   logic [COL_W-1:0]  win_row_o, win_col_o;
   logic [2*COL_W-1:0] exp_c_q[$];
`endif

   logic [WB-1:0] exp_q[$];
   int            tests_run = 0;
   int            tests_failed = 0;
   int            cyc = 0;
   int            win_cnt = 0, done_cnt = 0, stall_cnt = 0;
   int            last_win_cyc = 0, done_cyc = 0;
   logic [WB-1:0] first_win = '0, last_win = '0, held_win = '0;
   bit            hold_pending = 0;
   bit            stall_mode = 0;

   sliding_window_gen #(.DATA_W(DATA_W), .MAX_COLS(MAX_COLS), .WIN(WIN), .COL_W(COL_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .cfg_cols_i  (cfg_cols_i),
      .cfg_rows_i  (cfg_rows_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .pix_i       (pix_i),
      .pix_valid_i (pix_valid_i),
      .pix_ready_o (pix_ready_o),
      .win_o       (win_o),
      .win_valid_o (win_valid_o),
      .win_ready_i (win_ready_i),
`ifdef SWG_COORD_EN
      .win_row_o   (win_row_o),
      .win_col_o   (win_col_o),
`endif
      .dbg_state_o (dbg_state_o)
   );

   // Clock / reset and cycle count
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Window ready: always high, or high one cycle in three when stalling
   initial forever begin
      @(posedge clk);
      #1;
      win_ready_i = stall_mode ? ((cyc % 3) == 0) : 1'b1;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [WB-1:0] exp_win(input int row, input int col);
      logic [WB-1:0] w = '0;
      for (int rr = 0; rr < WIN; rr++)
         for (int cc = 0; cc < WIN; cc++)
            w[(rr*WIN+cc)*DATA_W +: DATA_W] = 8'((row - WIN + 1 + rr) * 16 + (col - WIN + 1 + cc));
      return w;
   endfunction

   // Monitor: pops the scoreboard on each window transfer, checks hold and backpressure
   always @(negedge clk) begin
      if (rst_n) begin
         if (win_valid_o && hold_pending) check("win_hold", win_o, held_win);
         if (win_valid_o && !win_ready_i) check("pix_ready_stall", pix_ready_o, 0);
         if (pix_valid_i && !pix_ready_o) stall_cnt++;
         if (win_valid_o && win_ready_i) begin
            hold_pending = 0;
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("FAIL win_unexpected: got %0h expected none", win_o);
            end else begin
               check("win_data", win_o, exp_q.pop_front());
            end
`ifdef SWG_COORD_EN
            if (exp_c_q.size() != 0) check("win_coord", {win_row_o, win_col_o}, exp_c_q.pop_front());
`endif
            win_cnt++;
            if (win_cnt == 1) first_win = win_o;
            last_win     = win_o;
            last_win_cyc = cyc;
         end else if (win_valid_o) begin
            hold_pending = 1;
            held_win     = win_o;
         end else begin
            hold_pending = 0;
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end else begin
         hold_pending = 0;
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_done"}, done_o, 0);
      check({tag, "_pix_ready"}, pix_ready_o, 0);
      check({tag, "_win_valid"}, win_valid_o, 0);
      check({tag, "_win"}, win_o, 0);
      check({tag, "_state"}, dbg_state_o, 0);
`ifdef SWG_COORD_EN
      check({tag, "_coord"}, {win_row_o, win_col_o}, 0);
`endif
   endtask

   task automatic try_start(input int cols, input int rows);
      @(posedge clk); #1;
      cfg_cols_i = COL_W'(cols);
      cfg_rows_i = COL_W'(rows);
      start_i    = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      check("bad_cfg_busy", busy_o, 0);
      check("bad_cfg_state", dbg_state_o, 0);
   endtask

   // Drives one frame of pix=row*16+col; abort_after>=0 resets the DUT before that pixel index
   task automatic run_frame(input int cols, input int rows, input int abort_after, input bit poke_start);
      int idx = 0;
      int budget;
      win_cnt   = 0;
      done_cnt  = 0;
      stall_cnt = 0;
      @(posedge clk); #1;
      cfg_cols_i = COL_W'(cols);
      cfg_rows_i = COL_W'(rows);
      start_i    = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      check("busy_after_start", busy_o, 1);
      @(posedge clk); #1;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < cols; c++) begin
            if (idx == abort_after) begin
               pix_valid_i = 1'b0;
               rst_n = 1'b0;
               @(posedge clk); #1;
               rst_n = 1'b1;
               exp_q.delete();
`ifdef SWG_COORD_EN
               exp_c_q.delete();
`endif
               @(negedge clk);
               check_idle_outputs("abort");
               repeat (10) @(negedge clk);
               check("abort_no_done", done_cnt, 0);
               return;
            end
            pix_i       = 8'(r * 16 + c);
            pix_valid_i = 1'b1;
            if (poke_start && idx == 7) begin
               start_i    = 1'b1;
               cfg_cols_i = COL_W'(7);
               cfg_rows_i = COL_W'(3);
            end
            if (poke_start && idx == 8) begin
               start_i    = 1'b0;
               cfg_cols_i = COL_W'(cols);
               cfg_rows_i = COL_W'(rows);
            end
            budget = 0;
            @(negedge clk);
            while (!pix_ready_o && budget < 50) begin
               budget++;
               @(negedge clk);
            end
            if (budget >= 50) begin
               check("pix_accept_timeout", 1, 0);
               pix_valid_i = 1'b0;
               start_i     = 1'b0;
               return;
            end
            @(posedge clk); #1;
            if (r >= WIN - 1 && c >= WIN - 1) begin
               exp_q.push_back(exp_win(r, c));
`ifdef SWG_COORD_EN
               exp_c_q.push_back({COL_W'(r), COL_W'(c)});
`endif
            end
            idx++;
         end
      end
      pix_valid_i = 1'b0;
      start_i     = 1'b0;
      budget = 0;
      while (done_cnt == 0 && budget < 200) begin
         budget++;
         @(negedge clk);
      end
      if (done_cnt == 0) check("done_timeout", 0, 1);
      repeat (3) @(negedge clk);
      check("win_count", win_cnt, (rows - WIN + 1) * (cols - WIN + 1));
      check("done_count", done_cnt, 1);
      check("queue_empty", exp_q.size(), 0);
      check("done_after_last_win", done_cyc, last_win_cyc + 1);
      check("busy_after_done", busy_o, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset");

      try_start(2, 4);
      try_start(541, 4);
      try_start(5, 2);

      run_frame(5, 4, -1, 0);
      check("first_win_5x4", first_win, 72'h222120121110020100);
      check("last_win_5x4", last_win, 72'h343332242322141312);

      stall_mode = 1;
      run_frame(5, 4, -1, 0);
      stall_mode = 0;
      check("stall_seen", stall_cnt > 0, 1);
      check("first_win_stall", first_win, 72'h222120121110020100);

      run_frame(5, 4, -1, 1);

      run_frame(540, 3, -1, 0);
      check("last_win_540", last_win, 72'h3b3a392b2a291b1a19);

      run_frame(5, 4, 11, 0);

      run_frame(5, 4, -1, 0);
      check("first_win_after_abort", first_win, 72'h222120121110020100);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sliding_window_gen.md
Name: sliding_window_gen

Overview:
- Parametrised successor of the fixed 3x3, 540-column row buffer.
- Accepts a raster pixel stream from the memory controller with a valid/ready handshake.
- Holds WIN-1 previous lines in line buffers plus a WIN x WIN shift-register window.
- Emits one full WINxWIN window per valid output position to the filter core, with backpressure.
- Frame size is runtime-configurable up to MAX_COLS columns, and done_o is reported to the controller.

Parameters:
- DATA_W, 8, pixel width in bits.
- MAX_COLS, 540, maximum image width; sets line-buffer depth.
- WIN, 3, window edge length (odd, 3..7).
- COL_W, 10, column/row counter width; must satisfy 2^COL_W > MAX_COLS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start_i  in  1  frame start pulse from controller.
- cfg_cols_i  in  COL_W  image width; sampled on accepted start.
- cfg_rows_i  in  COL_W  image height; sampled on accepted start.
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  one-cycle pulse when the frame is complete.
- pix_i  in  DATA_W  input pixel, raster order.
- pix_valid_i  in  1  input pixel valid.
- pix_ready_o  out  1  block can accept a pixel.
- win_o  out  WIN*WIN*DATA_W  window; element (r,c) at [(r*WIN+c)*DATA_W +: DATA_W]; r=0 is the oldest row, c=0 the leftmost column.
- win_valid_o  out  1  window valid.
- win_ready_i  in  1  core accepts the window.

Behaviour:
- Reset: all outputs are 0; state is IDLE; counters and the window register are 0. Line-buffer storage is not reset.
- Reset mid-frame aborts the frame. No done_o pulse is produced for the aborted frame.
- State IDLE:
  - start_i is accepted only if WIN <= cfg_cols_i <= MAX_COLS and cfg_rows_i >= WIN. Otherwise it is ignored and the block stays IDLE.
  - On an accepted start: latch the configuration, clear the counters, go to RUN.
- start_i outside IDLE is ignored.
- State RUN:
  - pix_ready_o = !win_valid_o || win_ready_i. The output stage is a single register with skid-free bubble handling.
  - Accept a pixel on pix_valid_i && pix_ready_o.
  - Each accepted pixel at (row, col) does the following:
    - Read column col from all WIN-1 line buffers.
    - Shift the window one column left and insert {lines, pix_i} as column WIN-1 (the newest row at r=WIN-1).
    - Write the line buffers as a shift chain: line k+1 takes the old line k value, and line 0 takes pix_i.
    - Advance col; on col == cols-1, wrap col to 0 and increment row.
  - A window is produced when row >= WIN-1 && col >= WIN-1 (valid-only, no padding).
  - win_o and win_valid_o are registered and appear the cycle after the producing pixel is accepted.
  - win_valid_o stays high, with win_o held stable, until win_ready_i.
  - Windows per frame = (rows-WIN+1)*(cols-WIN+1).
  - Window columns never straddle a row wrap. The first WIN-1 columns of every row are non-producing, so stale columns are flushed.
  - After the last pixel (rows-1, cols-1) is accepted, go to DRAIN. pix_ready_o is 0 in DRAIN and IDLE.
- State DRAIN: when the output register is empty, or is emptied this cycle, pulse done_o, go to IDLE, and clear busy_o the same cycle.
- Arithmetic: counters are COL_W bits unsigned. Row and column comparisons use the latched configuration. No counter wraps beyond cfg-1.
- Simultaneous output handoff and new production in one cycle: the register is reloaded and win_valid_o stays high.

Optional Feature:
- Macro SWG_COORD_EN.
- When defined, two additional output ports exist:
  - win_row_o [COL_W-1:0]: image row of the window's bottom-right pixel.
  - win_col_o [COL_W-1:0]: image column of the window's bottom-right pixel.
  - Both are registered alongside win_o, reset to 0, and held with win_valid_o.
- When not defined, the ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package swg_pkg holds:
  - FSM state encoding (IDLE=0, RUN=1, DRAIN=2).
  - Localparam WIN_BITS = WIN*WIN*DATA_W.
  - An index function for the (r,c) element offset.
- Sub-module swg_line_buf: one MAX_COLS x DATA_W register array with combinational read, synchronous write and write enable. It is instantiated WIN-1 times in a generate loop.

Test Plan:
- WIN=3, cols=5, rows=4, pix=row*16+col, ready always high:
  - Exactly 6 windows.
  - First window appears after pixel (2,2) with center 0x11, r0 = {00,01,02}, r2 = {20,21,22}.
  - done_o pulses one cycle after the last window.
- Same frame with win_ready_i toggling 1-of-3 cycles: win_o stays stable while stalled, pix_ready_o deasserts, and the window sequence is identical with no loss or duplication.
- cols=540 (MAX_COLS), rows=3: 538 windows; the last window is columns 537..539.
- Configuration bounds and start handling:
  - start_i with cfg_cols_i=2 is ignored; busy_o stays 0.
  - start_i with cfg_cols_i=541 is ignored.
  - start_i during RUN has no effect.
- rst_n low for 1 cycle mid-row 2:
  - All outputs are 0 and there is no done_o.
  - A new frame of 5x4 then reproduces the first scenario exactly.
- With SWG_COORD_EN: the first scenario reports (win_row_o, win_col_o) = (2,2), (2,3), (2,4), (3,2), (3,3), (3,4).
